buffer_fill_ctrl: RTL
=====================

Name: buffer_fill_ctrl

Overview:
- Sequencer that fills a 4x4 byte window held in four 1x4 row buffers from a byte-wide synchronous memory.
- Issues 16 pipelined reads in row-major order and drives the per-row load strobes, column select and load data of the row buffers.
- Presents the completed window to the downstream compute stage with a valid/ready handshake.
- Sits between the memory read port and the four row buffers, and is started by the top-level controller.

Parameters:
ADDR_W, 16, width of memory address, base_addr and row_stride

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  request a window fill; sampled only in IDLE
base_addr  in  ADDR_W  address of window element (row 0, col 0); captured on accepted start
row_stride  in  ADDR_W  address distance between consecutive window rows; captured on accepted start
mem_rd  out  1  memory read enable
mem_addr  out  ADDR_W  memory read address
mem_data  in  8  read data, valid exactly 1 cycle after mem_rd
buf_ld  out  4  one-hot row load strobe; bit r loads row buffer r
buf_col  out  2  column written in the strobed row buffer
buf_data  out  8  byte to load; equals mem_data combinationally
win_valid  out  1  window complete and stable
win_ready  in  1  consumer accepts window
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse after handshake completes

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - mem_rd, mem_addr, buf_ld, buf_col, win_valid, busy and done all go to 0.
  - Captured base and stride clear to 0; element counter clears to 0.
  - Reset mid-operation aborts the fill immediately. Row buffer contents are not the controller's concern.
- States: IDLE -> FETCH -> DRAIN -> HOLD -> IDLE.
- IDLE:
  - On clk edge with start=1: capture base_addr and row_stride, set counter idx=0, go to FETCH.
  - start=0: remain in IDLE.
- FETCH, 16 cycles, idx 0..15:
  - mem_rd=1.
  - mem_addr = base + (idx[3:2] * stride) + idx[1:0], computed modulo 2^ADDR_W (wrap, no saturation).
  - idx increments each cycle.
  - After idx=15, go to DRAIN.
  - Row offset uses an accumulator (row_base += stride at each idx[1:0]==3); no multiplier.
- Load pipeline:
  - A 1-cycle delayed copy of (valid, idx) drives the buffer outputs.
  - In the cycle after a read: buf_ld = one-hot(idx_d[3:2]), buf_col = idx_d[1:0], buf_data = mem_data.
  - buf_ld=0 when no read was issued in the previous cycle.
- DRAIN (1 cycle):
  - mem_rd=0; the last load (row 3, col 3) occurs here.
  - Next state: HOLD.
- HOLD:
  - win_valid=1; held until a clk edge with win_ready=1.
  - On that edge, go to IDLE and assert done for the following cycle.
  - win_ready outside HOLD is ignored.
- Timing, with start sampled at edge 0:
  - mem_rd high cycles 1..16.
  - buf_ld active cycles 2..17.
  - win_valid first high cycle 18.
  - With win_ready tied 1: done in cycle 19, busy low in cycle 19.
- Boundary conditions:
  - start while busy is ignored, with no effect on the captured addresses.
  - start in the done cycle (state already IDLE) is accepted normally, giving back-to-back fills.
  - Base and stride changes after capture have no effect until the next accepted start.
  - row_stride=0 is legal: all rows load the same four bytes.
  - Exactly one bit of buf_ld is high at any time, or none.

Test Plan:
- Basic fill:
  - Stimulus: base=0x0100, stride=0x0010, memory[a]=a[7:0], win_ready=1.
  - Required: mem_addr sequence 0x100-0x103, 0x110-0x113, 0x120-0x123, 0x130-0x133 in cycles 1..16.
  - Required: buf_ld 0001 x4, 0010 x4, 0100 x4, 1000 x4 in cycles 2..17, with buf_col cycling 0,1,2,3.
  - Required: buf_data matches the low address byte of the read issued the previous cycle.
  - Required: win_valid in cycle 18, done in cycle 19.
- Backpressure:
  - Stimulus: win_ready=0 for cycles 18..23, then 1.
  - Required: win_valid stays 1 and buf_ld stays 0 through cycle 23; done in cycle 25; busy=0 in cycle 25.
- Start while busy:
  - Stimulus: second start pulse with base=0x0500 at cycle 8.
  - Required: addresses continue 0x120.., and no second fill follows.
  - Required: a start in the done cycle begins a new fill with mem_rd high in the next cycle.
- Address wrap:
  - Stimulus: base=0xFFFE, stride=0x0001.
  - Required: row 0 addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; row 3 addresses 0x0001-0x0004.
- Reset mid-fetch:
  - Stimulus: drive rst=0 asynchronously between edges 7 and 8, release at cycle 10.
  - Required: mem_rd, buf_ld, busy and win_valid drop to 0 immediately without waiting for a clock edge.
  - Required: state is IDLE after release, and a new start with base=0x0200 restarts cleanly from 0x0200.
- Zero stride:
  - Stimulus: base=0x0040, stride=0.
  - Required: each of the 4 rows reads 0x40-0x43, giving 16 loads with correct one-hot row strobes.

Source files
------------

// File: rtl/buffer_fill_ctrl.sv
// Window fill sequencer: streams a 4x4 byte window from a byte-wide synchronous
// memory into four 1x4 row buffers, then offers the window with valid/ready.
module buffer_fill_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] row_stride_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [3:0]        buf_ld_o,
  output logic [1:0]        buf_col_o,
  output logic [7:0]        buf_data_o,
  output logic              win_valid_o,
  input  logic              win_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;
  logic [3:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic              ld_vld_q;
  logic [3:0]        ld_idx_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      row_off_q <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      ld_vld_q  <= 1'b0;
      ld_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      row_off_q <= row_off_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      ld_vld_q  <= mem_rd_o;
      ld_idx_q  <= idx_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    stride_d  = stride_q;
    row_off_d = row_off_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d    = base_addr_i;
          stride_d  = row_stride_i;
          row_off_d = '0;
          idx_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        idx_d = idx_q + 4'd1;
        // Row offset accumulates one stride per completed row, avoiding a multiplier.
        if (idx_q[1:0] == 2'd3) row_off_d = row_off_q + stride_q;
        if (idx_q == 4'd15) state_d = DRAIN;
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (win_ready_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_o   = (state_q == FETCH);
  assign mem_addr_o = mem_rd_o ? (base_q + row_off_q + {{(ADDR_W-2){1'b0}}, idx_q[1:0]}) : '0;

  // Loads trail reads by one cycle to line up with the memory's read latency.
  assign buf_ld_o    = ld_vld_q ? (4'b0001 << ld_idx_q[3:2]) : 4'b0000;
  assign buf_col_o   = ld_idx_q[1:0];
  assign buf_data_o  = mem_data_i;
  assign win_valid_o = (state_q == HOLD);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule
